run_control: RTL and testbench

- Synthesizable run-control sequencer for the pipelined core.
- Gates the core's clock-enable `cpu_run`, counts executed cycles and enforces a cycle-limit watchdog.
- Captures the return value when the core halts.
- Offers pause, single-step and resume for debug.
- Sits between the testbench/debug host and the core; exposes done/timeout status and the captured result.

---
 rtl/run_control_pkg.sv | 20 ++
 rtl/run_control_if.sv | 28 ++
 rtl/run_watchdog.sv | 34 +++
 rtl/run_control.sv | 98 +++++++++
 tb/tb_run_control.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/run_control_pkg.sv
// Shared types and defaults for the run-control sequencer and its watchdog.
package run_control_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RUN     = 3'd1,
    ST_PAUSED  = 3'd2,
    ST_STEP    = 3'd3,
    ST_DONE    = 3'd4,
    ST_TIMEOUT = 3'd5
  } run_state_t;

  localparam int unsigned DEFAULT_CYCLE_LIMIT = 500;

  // States in which the core is allowed to advance.
  function automatic logic is_run_state(run_state_t s);
    return (s == ST_RUN) || (s == ST_STEP);
  endfunction

endpackage

// File: rtl/run_control_if.sv
// Host-facing control/status bundle of the run-control sequencer.
interface run_control_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             pause_req;
  logic             resume_req;
  logic             step_req;
  logic             isHalt;
  logic [WIDTH-1:0] ret_val;
  logic             cpu_run;
  logic             busy;
  logic             paused;
  logic             done;
  logic             timeout;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] cycle_count;

  modport master (
    output start, pause_req, resume_req, step_req, isHalt, ret_val,
    input  cpu_run, busy, paused, done, timeout, result, cycle_count
  );

  modport slave (
    input  start, pause_req, resume_req, step_req, isHalt, ret_val,
    output cpu_run, busy, paused, done, timeout, result, cycle_count
  );
endinterface

// File: rtl/run_watchdog.sv
// Run-cycle counter with a combinational "this increment reaches the limit" flag.
module run_watchdog
  import run_control_pkg::*;
#(
  parameter int          WIDTH       = 32,
  parameter int unsigned CYCLE_LIMIT = DEFAULT_CYCLE_LIMIT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count,
  output logic             limit_hit
);

  logic [WIDTH-1:0] count_reg;
  logic [WIDTH-1:0] count_inc;

  assign count_inc = count_reg + 1'b1;
  // Compared against the post-increment value so the limit cycle itself is counted.
  assign limit_hit = (count_inc == WIDTH'(CYCLE_LIMIT));
  assign count     = count_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (inc) begin
      count_reg <= count_inc;
    end
  end

endmodule

// File: rtl/run_control.sv
// Run-control sequencer: gates the core clock-enable, supports pause/step/resume,
// captures the halt return value and stops runaway runs via the watchdog.
module run_control
  import run_control_pkg::*;
#(
  parameter int          WIDTH       = 32,
  parameter int unsigned CYCLE_LIMIT = DEFAULT_CYCLE_LIMIT
) (
  input  logic          clk,
  input  logic          rst,
  run_control_if.slave  bus
);

  run_state_t       state_reg, state_next;
  logic [WIDTH-1:0] result_reg, result_next;
  logic             cpu_run_reg, busy_reg, paused_reg, done_reg, timeout_reg;
  logic             count_clear;
  logic             limit_hit;
  logic [WIDTH-1:0] count;

  run_watchdog #(
    .WIDTH       (WIDTH),
    .CYCLE_LIMIT (CYCLE_LIMIT)
  ) u_watchdog (
    .clk       (clk),
    .rst       (rst),
    .clear     (count_clear),
    .inc       (cpu_run_reg),
    .count     (count),
    .limit_hit (limit_hit)
  );

  always_comb begin
    state_next  = state_reg;
    result_next = result_reg;
    count_clear = 1'b0;
    case (state_reg)
      ST_IDLE, ST_DONE, ST_TIMEOUT: begin
        if (bus.start) begin
          state_next  = ST_RUN;
          result_next = '0;
          count_clear = 1'b1;
        end
      end
      ST_RUN, ST_STEP: begin
        // Halt outranks the watchdog so a core finishing on the last allowed cycle still reports done.
        if (bus.isHalt) begin
          state_next  = ST_DONE;
          result_next = bus.ret_val;
        end else if (limit_hit) begin
          state_next = ST_TIMEOUT;
        end else if (state_reg == ST_STEP) begin
          state_next = ST_PAUSED;
        end else if (bus.pause_req) begin
          state_next = ST_PAUSED;
        end
      end
      ST_PAUSED: begin
        if (bus.resume_req) begin
          state_next = ST_RUN;
        end else if (bus.step_req) begin
          state_next = ST_STEP;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Status flags are decoded from the next state so they change on the same edge as the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      result_reg  <= '0;
      cpu_run_reg <= 1'b0;
      busy_reg    <= 1'b0;
      paused_reg  <= 1'b0;
      done_reg    <= 1'b0;
      timeout_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      result_reg  <= result_next;
      cpu_run_reg <= is_run_state(state_next);
      busy_reg    <= is_run_state(state_next) || (state_next == ST_PAUSED);
      paused_reg  <= (state_next == ST_PAUSED);
      done_reg    <= (state_next == ST_DONE);
      timeout_reg <= (state_next == ST_TIMEOUT);
    end
  end

  assign bus.cpu_run     = cpu_run_reg;
  assign bus.busy        = busy_reg;
  assign bus.paused      = paused_reg;
  assign bus.done        = done_reg;
  assign bus.timeout     = timeout_reg;
  assign bus.result      = result_reg;
  assign bus.cycle_count = count;

endmodule

// File: tb/tb_run_control.sv
// Directed and randomized checks of run_control against a flag-based behavioural model.
module tb_run_control;

  localparam int WIDTH = 32;
  localparam int LIMIT = 500;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  run_control_if #(.WIDTH(WIDTH)) bus ();

  run_control #(.WIDTH(WIDTH), .CYCLE_LIMIT(LIMIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: which activity the sequencer is in, as independent flags.
  bit          m_run, m_step, m_paused, m_done, m_timeout;
  logic [31:0] m_count, m_result;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_step(input bit s, p, r, st, h, input logic [31:0] rv, input bit rs);
    logic [31:0] nxt;
    if (rs) begin
      {m_run, m_step, m_paused, m_done, m_timeout} = '0;
      m_count = 0;
      m_result = 0;
    end else if (m_run || m_step) begin
      nxt = m_count + 1;
      m_count = nxt;
      if (h) begin
        {m_run, m_step} = '0;
        m_done = 1;
        m_result = rv;
      end else if (nxt == LIMIT) begin
        {m_run, m_step} = '0;
        m_timeout = 1;
      end else if (m_step || p) begin
        {m_run, m_step} = '0;
        m_paused = 1;
      end
    end else if (m_paused) begin
      if (r) begin
        m_paused = 0;
        m_run = 1;
      end else if (st) begin
        m_paused = 0;
        m_step = 1;
      end
    end else if (s) begin
      {m_done, m_timeout} = '0;
      m_run = 1;
      m_count = 0;
      m_result = 0;
    end
  endtask

  task automatic cycle(input bit s = 0, p = 0, r = 0, st = 0, h = 0,
                       input logic [31:0] rv = 0, input bit rs = 0);
    @(negedge clk);
    bus.start = s;  bus.pause_req = p;  bus.resume_req = r;
    bus.step_req = st;  bus.isHalt = h;  bus.ret_val = rv;  rst = rs;
    model_step(s, p, r, st, h, rv, rs);
    @(posedge clk);
    #1;
    check("cpu_run", 32'(bus.cpu_run), 32'(m_run | m_step));
    check("busy", 32'(bus.busy), 32'(m_run | m_step | m_paused));
    check("paused", 32'(bus.paused), 32'(m_paused));
    check("done", 32'(bus.done), 32'(m_done));
    check("timeout", 32'(bus.timeout), 32'(m_timeout));
    check("result", bus.result, m_result);
    check("cycle_count", bus.cycle_count, m_count);
  endtask

  int n_run;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    {bus.start, bus.pause_req, bus.resume_req, bus.step_req, bus.isHalt} = '0;
    bus.ret_val = '0;
    rst = 1'b1;

    cycle(.rs(1));
    cycle(.rs(1));
    check("reset_cpu_run", 32'(bus.cpu_run), 0);
    check("reset_count", bus.cycle_count, 0);
    $display("[reset] outputs cleared");

    // Normal halt on the 10th run cycle.
    cycle(.s(1));
    for (int i = 0; i < 20 && !m_done; i++) cycle(.h(m_count == 9), .rv(42));
    check("t1_done", 32'(bus.done), 1);
    check("t1_result", bus.result, 42);
    check("t1_count", bus.cycle_count, 10);
    check("t1_cpu_run", 32'(bus.cpu_run), 0);
    check("t1_timeout", 32'(bus.timeout), 0);
    $display("[t1] halt: result=%0d count=%0d", bus.result, bus.cycle_count);

    // Watchdog with no halt.
    cycle(.s(1));
    n_run = int'(bus.cpu_run);
    for (int i = 0; i < 600 && !m_timeout; i++) begin
      cycle();
      n_run += int'(bus.cpu_run);
    end
    check("t2_run_cycles", n_run, LIMIT);
    check("t2_timeout", 32'(bus.timeout), 1);
    check("t2_count", bus.cycle_count, LIMIT);
    check("t2_result", bus.result, 0);
    $display("[t2] watchdog: run cycles=%0d count=%0d", n_run, bus.cycle_count);

    // Pause at run cycle 5, ignored inputs while paused, three steps, resume.
    cycle(.s(1));
    for (int i = 0; i < 10 && m_count != 4; i++) cycle();
    cycle(.p(1));
    check("t3_paused", 32'(bus.paused), 1);
    check("t3_pause_count", bus.cycle_count, 5);
    repeat (3) cycle(.s(1), .p(1), .h(1), .rv(13));
    check("t6_halt_in_paused", 32'(bus.paused), 1);
    check("t6_paused_count", bus.cycle_count, 5);
    repeat (3) begin
      cycle(.st(1));
      check("t3_step_pulse", 32'(bus.cpu_run), 1);
      cycle(.st(1), .p(1));
      check("t3_step_back", 32'(bus.paused), 1);
      cycle();
    end
    check("t3_step_count", bus.cycle_count, 8);
    cycle(.r(1), .st(1));
    check("t3_resume", 32'(bus.cpu_run), 1);
    check("t3_resume_paused", 32'(bus.paused), 0);
    cycle(.s(1));
    check("t6_start_in_run", bus.cycle_count, 9);
    $display("[t3] pause/step/resume: count=%0d", bus.cycle_count);

    // Halt collides with the limit cycle.
    for (int i = 0; i < 600 && m_count != LIMIT - 1; i++) cycle();
    cycle(.h(1), .rv(7));
    check("t4_done", 32'(bus.done), 1);
    check("t4_timeout", 32'(bus.timeout), 0);
    check("t4_result", bus.result, 7);
    check("t4_count", bus.cycle_count, LIMIT);
    $display("[t4] collision: result=%0d", bus.result);

    // Halt during a step.
    cycle(.s(1));
    cycle(.p(1));
    cycle(.st(1));
    cycle(.h(1), .rv(99));
    check("t4_step_done", 32'(bus.done), 1);
    check("t4_step_paused", 32'(bus.paused), 0);
    check("t4_step_result", bus.result, 99);
    $display("[t4] halt in step: result=%0d", bus.result);

    // Reset mid-run, then restart from DONE.
    cycle(.s(1));
    for (int i = 0; i < 200 && m_count != 99; i++) cycle();
    cycle(.rs(1));
    check("t5_rst_busy", 32'(bus.busy), 0);
    check("t5_rst_count", bus.cycle_count, 0);
    check("t5_rst_result", bus.result, 0);
    cycle(.s(1));
    cycle(.h(1), .rv(5));
    check("t5_halt_result", bus.result, 5);
    cycle(.s(1));
    check("t5_restart_result", bus.result, 0);
    check("t5_restart_count", bus.cycle_count, 0);
    check("t5_restart_run", 32'(bus.cpu_run), 1);
    $display("[t5] reset and restart: count=%0d", bus.cycle_count);

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      cycle(.s($urandom_range(7) == 0), .p($urandom_range(9) == 0),
            .r($urandom_range(9) == 0), .st($urandom_range(5) == 0),
            .h($urandom_range(59) == 0), .rv($urandom),
            .rs($urandom_range(299) == 0));
    end
    $display("[rand] 4000 cycles: last count=%0d", bus.cycle_count);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
